fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- IF stage of the pipelined MIPS core: holds the PC, drives the combinational instruction memory address, and registers the returned word into the IF/ID pipeline register.
- Handles stall, taken branch/jump redirect, exception entry to the handler and eret return.
- Detects fetch address errors: misaligned or outside instruction memory → AdEL.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset.
- HANDLER_PC, 32'h0000_4180, exception entry address.
- IM_BASE, 32'h0000_3000, lowest legal fetch address.
- IM_WORDS, 4096, instruction memory depth in words; last legal address is IM_BASE+4*IM_WORDS-4 (0x6FFC).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  reset, asynchronous, active-low.
- stall  in  1  hold PC and IF/ID (hazard unit).
- br_taken  in  1  branch/jump resolved taken in ID.
- br_target  in  32  redirect target.
- id_is_branch  in  1  instruction currently in ID is a branch/jump; marks the next captured instruction as a delay slot.
- exc_req  in  1  CP0 exception/interrupt taken.
- eret  in  1  eret executing; return to epc.
- epc  in  32  return address from CP0.
- im_addr  out  32  fetch address to instruction memory; equals pc.
- im_instr  in  32  instruction word, combinational from im_addr.
- id_instr  out  32  IF/ID instruction.
- id_pc  out  32  IF/ID PC.
- id_pc8  out  32  id_pc+8, link value.
- id_exccode  out  5  0 = none, 4 = AdEL.
- id_bd  out  1  IF/ID instruction is in a branch delay slot.

Behaviour:
- Reset (reset=0, asynchronous, any time): pc=RESET_PC; id_instr=0, id_pc=0, id_pc8=8, id_exccode=0, id_bd=0. Deassertion is synchronous in effect: the first fetch is RESET_PC on the first rising edge after release.
- im_addr=pc, combinational; no fetch latency beyond the memory. IF/ID updates one edge after pc is presented.
- fetch_err = (pc[1:0]!=0) | (pc<IM_BASE) | (pc>IM_BASE+4*IM_WORDS-4). Unsigned compares on the full 32-bit value.
- Per-edge priority, highest first:
  - exc_req: pc←HANDLER_PC; IF/ID flushed (instr=0, pc=0, pc8=8, exccode=0, bd=0). Overrides stall, eret and br_taken.
  - eret: pc←epc; IF/ID flushed. No delay slot after eret. Overrides stall.
  - stall: pc and all IF/ID outputs hold. br_taken is ignored this cycle; ID must keep asserting it until the stall clears.
  - otherwise IF/ID captures: id_instr = fetch_err ? 0 : im_instr; id_pc=pc; id_pc8=pc+8; id_exccode = fetch_err ? 4 : 0; id_bd=id_is_branch.
    - pc ← br_taken ? br_target : pc+4.
    - The word fetched during the branch's ID cycle is the delay slot and is always captured, never squashed.
- pc+4 wraps modulo 2^32. pc is never force-aligned; a misaligned pc propagates and raises AdEL on each fetch until exc_req redirects.
- A faulting fetch is a NOP with exccode 4. This block never asserts exc_req itself; CP0 does so later.
- Flushed or bubble IF/ID contents (instr 0) decode as sll $0,$0,0.

Test Plan:
- Reset/sequential: hold reset=0 for 3 cycles, release; rom[0..2]=0x3C010001,0x34210002,0x00000000 → im_addr 0x3000,0x3004,0x3008 on successive cycles; id_instr follows one cycle later; id_pc8=0x3008 for the first word; outputs are reset values while reset=0.
- Stall: assert stall for 2 cycles while pc=0x3008 → pc and id_* unchanged for 2 edges; resume at 0x300C.
- Branch + delay slot: id_is_branch=1, br_taken=1, br_target=0x3100 with pc=0x3010 → word at 0x3010 captured with id_bd=1, next im_addr=0x3100, id_bd returns 0 afterward.
- Stall+branch: stall=1 and br_taken=1 together → pc held; next cycle stall=0, br_taken=1 → pc=0x3100.
- Exception vs stall: exc_req=1 with stall=1 and br_taken=1 → pc=0x4180, id_instr=0, id_pc=0, id_bd=0; eret with epc=0x3014 → pc=0x3014, IF/ID flushed.
- Address error: eret with epc=0x3002 → captured id_instr=0, id_exccode=4, id_pc=0x3002; then pc=0x3006, also AdEL. Branch to 0x7000 → AdEL; branch to 0x6FFC → normal fetch; mid-run reset → pc=0x3000 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Signal bundle between the IF stage, the instruction memory, the hazard/CP0 control
// and the IF/ID pipeline register consumers.
interface fetch_stage_if;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        id_is_branch;
    logic        exc_req;
    logic        eret;
    logic [31:0] epc;
    logic [31:0] im_addr;
    logic [31:0] im_instr;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc8;
    logic [4:0]  id_exccode;
    logic        id_bd;

    modport master (
        input  stall, br_taken, br_target, id_is_branch, exc_req, eret, epc, im_instr,
        output im_addr, id_instr, id_pc, id_pc8, id_exccode, id_bd
    );

    modport slave (
        output stall, br_taken, br_target, id_is_branch, exc_req, eret, epc, im_instr,
        input  im_addr, id_instr, id_pc, id_pc8, id_exccode, id_bd
    );
endinterface

// File: rtl/fetch_stage.sv
// MIPS IF stage: owns the PC, presents it to instruction memory and loads the IF/ID
// register, handling stall, branch redirect, exception entry, eret and AdEL on fetch.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] IM_BASE    = 32'h0000_3000,
    parameter int          IM_WORDS   = 4096
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
);

    localparam logic [31:0] IM_LAST    = IM_BASE + 32'(4 * IM_WORDS) - 32'd4;
    localparam logic [4:0]  EXC_NONE   = 5'd0;
    localparam logic [4:0]  EXC_ADEL   = 5'd4;

    // stage p0: program counter presented to instruction memory
    logic [31:0] pc_p0, pc_nxt;

    // stage p1: IF/ID pipeline register
    logic [31:0] instr_p1, pc_p1, pc8_p1;
    logic [4:0]  exccode_p1;
    logic        bd_p1;
    logic [31:0] instr_nxt, pc1_nxt, pc8_nxt;
    logic [4:0]  exccode_nxt;
    logic        bd_nxt;

    logic fetch_err;

    // Unsigned compares on the full address; pc is never force-aligned.
    assign fetch_err = (pc_p0[1:0] != 2'b00) | (pc_p0 < IM_BASE) | (pc_p0 > IM_LAST);

    always_comb begin
        pc_nxt      = pc_p0;
        instr_nxt   = instr_p1;
        pc1_nxt     = pc_p1;
        pc8_nxt     = pc8_p1;
        exccode_nxt = exccode_p1;
        bd_nxt      = bd_p1;
        if (bus.exc_req || bus.eret) begin
            // Flush leaves a bubble that decodes as sll $0,$0,0.
            pc_nxt      = bus.exc_req ? HANDLER_PC : bus.epc;
            instr_nxt   = 32'd0;
            pc1_nxt     = 32'd0;
            pc8_nxt     = 32'd8;
            exccode_nxt = EXC_NONE;
            bd_nxt      = 1'b0;
        end else if (!bus.stall) begin
            pc_nxt      = bus.br_taken ? bus.br_target : pc_p0 + 32'd4;
            instr_nxt   = fetch_err ? 32'd0 : bus.im_instr;
            pc1_nxt     = pc_p0;
            pc8_nxt     = pc_p0 + 32'd8;
            exccode_nxt = fetch_err ? EXC_ADEL : EXC_NONE;
            bd_nxt      = bus.id_is_branch;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_p0      <= RESET_PC;
            instr_p1   <= 32'd0;
            pc_p1      <= 32'd0;
            pc8_p1     <= 32'd8;
            exccode_p1 <= EXC_NONE;
            bd_p1      <= 1'b0;
        end else begin
            pc_p0      <= pc_nxt;
            instr_p1   <= instr_nxt;
            pc_p1      <= pc1_nxt;
            pc8_p1     <= pc8_nxt;
            exccode_p1 <= exccode_nxt;
            bd_p1      <= bd_nxt;
        end
    end

    assign bus.im_addr    = pc_p0;
    assign bus.id_instr   = instr_p1;
    assign bus.id_pc      = pc_p1;
    assign bus.id_pc8     = pc8_p1;
    assign bus.id_exccode = exccode_p1;
    assign bus.id_bd      = bd_p1;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: each step queues the expected IF/ID contents and
// next fetch address, which are popped and compared after the clock edge.
module tb_fetch_stage;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    fetch_stage_if bus ();

    fetch_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        case (a)
            32'h0000_3000: rom_word = 32'h3C01_0001;
            32'h0000_3004: rom_word = 32'h3421_0002;
            32'h0000_3008: rom_word = 32'h0000_0000;
            default:       rom_word = a ^ 32'h5A5A_0000;
        endcase
    endfunction

    assign bus.im_instr = rom_word(bus.im_addr);

    typedef struct {
        logic [31:0] next_pc;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc8;
        logic [4:0]  exc;
        logic        bd;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic st, input logic br, input logic [31:0] tgt,
                         input logic isbr, input logic exc, input logic er,
                         input logic [31:0] ep);
        bus.stall        = st;
        bus.br_taken     = br;
        bus.br_target    = tgt;
        bus.id_is_branch = isbr;
        bus.exc_req      = exc;
        bus.eret         = er;
        bus.epc          = ep;
    endtask

    task automatic step(input string tag, input logic [31:0] cur_pc, input logic [31:0] nxt_pc,
                        input logic [31:0] instr, input logic [31:0] pc,
                        input logic [31:0] pc8, input logic [4:0] exc, input logic bd);
        exp_t e;
        exp_t g;
        check({tag, ".im_addr_pre"}, bus.im_addr, cur_pc);
        e.next_pc = nxt_pc;
        e.instr   = instr;
        e.pc      = pc;
        e.pc8     = pc8;
        e.exc     = exc;
        e.bd      = bd;
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        check({tag, ".im_addr"},    bus.im_addr,           g.next_pc);
        check({tag, ".id_instr"},   bus.id_instr,          g.instr);
        check({tag, ".id_pc"},      bus.id_pc,             g.pc);
        check({tag, ".id_pc8"},     bus.id_pc8,            g.pc8);
        check({tag, ".id_exccode"}, 32'(bus.id_exccode),   32'(g.exc));
        check({tag, ".id_bd"},      32'(bus.id_bd),        32'(g.bd));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".im_addr"},    bus.im_addr,         32'h0000_3000);
        check({tag, ".id_instr"},   bus.id_instr,        32'h0);
        check({tag, ".id_pc"},      bus.id_pc,           32'h0);
        check({tag, ".id_pc8"},     bus.id_pc8,          32'h8);
        check({tag, ".id_exccode"}, 32'(bus.id_exccode), 32'h0);
        check({tag, ".id_bd"},      32'(bus.id_bd),      32'h0);
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 32'h0, 0, 0, 0, 32'h0);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("in_reset");
        reset = 1'b1;

        // Sequential fetch
        step("seq0", 32'h3000, 32'h3004, 32'h3C01_0001, 32'h3000, 32'h3008, 5'd0, 0);
        step("seq1", 32'h3004, 32'h3008, 32'h3421_0002, 32'h3004, 32'h300C, 5'd0, 0);

        // Stall two cycles at 0x3008
        drive(1, 0, 32'h0, 0, 0, 0, 32'h0);
        step("stall0", 32'h3008, 32'h3008, 32'h3421_0002, 32'h3004, 32'h300C, 5'd0, 0);
        step("stall1", 32'h3008, 32'h3008, 32'h3421_0002, 32'h3004, 32'h300C, 5'd0, 0);
        drive(0, 0, 32'h0, 0, 0, 0, 32'h0);
        step("resume", 32'h3008, 32'h300C, 32'h0, 32'h3008, 32'h3010, 5'd0, 0);
        step("seq2", 32'h300C, 32'h3010, 32'h300C ^ 32'h5A5A_0000, 32'h300C, 32'h3014, 5'd0, 0);

        // Branch with delay slot
        drive(0, 1, 32'h3100, 1, 0, 0, 32'h0);
        step("br_ds", 32'h3010, 32'h3100, 32'h3010 ^ 32'h5A5A_0000, 32'h3010, 32'h3018, 5'd0, 1);
        drive(0, 0, 32'h0, 0, 0, 0, 32'h0);
        step("br_tgt", 32'h3100, 32'h3104, 32'h3100 ^ 32'h5A5A_0000, 32'h3100, 32'h3108, 5'd0, 0);

        // Stall overrides branch; branch held until stall clears
        drive(1, 1, 32'h3100, 0, 0, 0, 32'h0);
        step("stbr_hold", 32'h3104, 32'h3104, 32'h3100 ^ 32'h5A5A_0000, 32'h3100, 32'h3108, 5'd0, 0);
        drive(0, 1, 32'h3100, 0, 0, 0, 32'h0);
        step("stbr_go", 32'h3104, 32'h3100, 32'h3104 ^ 32'h5A5A_0000, 32'h3104, 32'h310C, 5'd0, 0);

        // Exception beats stall, branch and eret
        drive(1, 1, 32'h3200, 1, 1, 1, 32'h3014);
        step("exc", 32'h3100, 32'h4180, 32'h0, 32'h0, 32'h8, 5'd0, 0);
        drive(0, 0, 32'h0, 0, 0, 0, 32'h0);
        step("handler", 32'h4180, 32'h4184, 32'h4180 ^ 32'h5A5A_0000, 32'h4180, 32'h4188, 5'd0, 0);

        // eret overrides stall and flushes
        drive(1, 0, 32'h0, 0, 0, 1, 32'h3014);
        step("eret", 32'h4184, 32'h3014, 32'h0, 32'h0, 32'h8, 5'd0, 0);
        drive(0, 0, 32'h0, 0, 0, 0, 32'h0);
        step("eret_ret", 32'h3014, 32'h3018, 32'h3014 ^ 32'h5A5A_0000, 32'h3014, 32'h301C, 5'd0, 0);

        // Misaligned return address keeps raising AdEL
        drive(0, 0, 32'h0, 0, 0, 1, 32'h3002);
        step("eret_mis", 32'h3018, 32'h3002, 32'h0, 32'h0, 32'h8, 5'd0, 0);
        drive(0, 0, 32'h0, 0, 0, 0, 32'h0);
        step("adel_mis0", 32'h3002, 32'h3006, 32'h0, 32'h3002, 32'h300A, 5'd4, 0);
        step("adel_mis1", 32'h3006, 32'h300A, 32'h0, 32'h3006, 32'h300E, 5'd4, 0);

        // Upper bound of instruction memory
        drive(0, 1, 32'h7000, 0, 0, 0, 32'h0);
        step("br_7000", 32'h300A, 32'h7000, 32'h0, 32'h300A, 32'h3012, 5'd4, 0);
        drive(0, 1, 32'h6FFC, 0, 0, 0, 32'h0);
        step("adel_hi", 32'h7000, 32'h6FFC, 32'h0, 32'h7000, 32'h7008, 5'd4, 0);
        drive(0, 0, 32'h0, 0, 0, 0, 32'h0);
        step("last_ok", 32'h6FFC, 32'h7000, 32'h6FFC ^ 32'h5A5A_0000, 32'h6FFC, 32'h7004, 5'd0, 0);
        step("past_end", 32'h7000, 32'h7004, 32'h0, 32'h7000, 32'h7008, 5'd4, 0);

        // Lower bound of instruction memory
        drive(0, 0, 32'h0, 0, 0, 1, 32'h2FFC);
        step("eret_lo", 32'h7004, 32'h2FFC, 32'h0, 32'h0, 32'h8, 5'd0, 0);
        drive(0, 0, 32'h0, 0, 0, 0, 32'h0);
        step("adel_lo", 32'h2FFC, 32'h3000, 32'h0, 32'h2FFC, 32'h3004, 5'd4, 0);

        // pc+4 and pc+8 wrap modulo 2^32
        drive(0, 0, 32'h0, 0, 0, 1, 32'hFFFF_FFFC);
        step("eret_top", 32'h3000, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h8, 5'd0, 0);
        drive(0, 0, 32'h0, 0, 0, 0, 32'h0);
        step("wrap", 32'hFFFF_FFFC, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'h4, 5'd4, 0);

        // Mid-run asynchronous reset takes effect before any clock edge
        step("pre_rst", 32'h0, 32'h4, 32'h0, 32'h0, 32'h8, 5'd4, 0);
        #2 reset = 1'b0;
        #1;
        check_reset_state("async_rst");
        @(posedge clk);
        #1;
        check_reset_state("rst_held");
        reset = 1'b1;
        step("post_rst", 32'h3000, 32'h3004, 32'h3C01_0001, 32'h3000, 32'h3008, 5'd0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
